// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared types and constants for the branch resolution stage
package branch_resolve_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_e;

    localparam int XLEN_DEF      = 32;
    localparam int ROB_TAG_W_DEF = 6;

    // Branch funct3 encodings, shared with the branch functional unit
    localparam logic [2:0] BR_OP_BEQ  = 3'b000;
    localparam logic [2:0] BR_OP_BNE  = 3'b001;
    localparam logic [2:0] BR_OP_BLT  = 3'b100;
    localparam logic [2:0] BR_OP_BGE  = 3'b101;
    localparam logic [2:0] BR_OP_BLTU = 3'b110;
    localparam logic [2:0] BR_OP_BGEU = 3'b111;

endpackage

// File: rtl/bru_upd_fifo.sv
// rtl/bru_upd_fifo.sv - synchronous FIFO holding predictor training updates
module bru_upd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - resolves branches against prediction, drives writeback, redirect and flush
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int ROB_TAG_W    = ROB_TAG_W_DEF,
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fu_valid,
    input  logic                 fu_taken,
    input  logic                 fu_link,
    input  logic [XLEN-1:0]      fu_target,
    input  logic [XLEN-1:0]      fu_pc,
    input  logic [ROB_TAG_W-1:0] fu_tag,
    input  logic                 pred_taken,
    input  logic [XLEN-1:0]      pred_target,
    output logic                 wb_valid,
    output logic [ROB_TAG_W-1:0] wb_tag,
    output logic [XLEN-1:0]      wb_data,
    output logic                 wb_mispredict,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 flush,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [XLEN-1:0]      upd_pc,
    output logic [XLEN-1:0]      upd_target,
    output logic                 upd_taken,
    output logic [15:0]          upd_drop_cnt
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam int UPD_W = 2 * XLEN + 1;

    br_state_e        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic             mispredict;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  correct_pc;
    logic             upd_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [UPD_W-1:0] fifo_dout;

    assign seq_pc     = fu_pc + XLEN'(4);
    assign correct_pc = fu_taken ? fu_target : seq_pc;
    assign mispredict = (fu_taken != pred_taken) |
                        (fu_taken & pred_taken & (fu_target != pred_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fu_valid) begin
                    accept = 1'b1;
                    if (mispredict) begin
                        state_next = ST_FLUSH;
                        cnt_next   = CNT_W'(FLUSH_CYCLES);
                    end
                end
            end
            ST_FLUSH: begin
                // Results seen here are younger than the mispredict and are squashed
                flush    = 1'b1;
                cnt_next = cnt - CNT_W'(1);
                if (cnt_next == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_tag         <= '0;
            wb_data        <= '0;
            wb_mispredict  <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            wb_valid       <= accept;
            redirect_valid <= accept & mispredict;
            if (accept) begin
                wb_tag        <= fu_tag;
                wb_data       <= fu_link ? seq_pc : '0;
                wb_mispredict <= mispredict;
            end
            if (accept && mispredict) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    assign upd_valid = ~fifo_empty;
    assign upd_pop   = upd_valid & upd_ready;
    assign {upd_pc, upd_taken, upd_target} = fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_drop_cnt <= '0;
        end else if (accept && fifo_full && !upd_pop && upd_drop_cnt != 16'hFFFF) begin
            upd_drop_cnt <= upd_drop_cnt + 16'd1;
        end
    end

    bru_upd_fifo #(
        .WIDTH (UPD_W),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ({fu_pc, fu_taken, fu_target}),
        .pop   (upd_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve with directed vectors
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        fu_valid, fu_taken, fu_link;
    logic [31:0] fu_target, fu_pc, pred_target;
    logic [5:0]  fu_tag;
    logic        pred_taken;
    logic        wb_valid, wb_mispredict, redirect_valid, flush, upd_valid, upd_ready, upd_taken;
    logic [5:0]  wb_tag;
    logic [31:0] wb_data, redirect_pc, upd_pc, upd_target;
    logic [15:0] upd_drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [38:0] wb_q[$];
    logic [31:0] rd_q[$];
    logic [64:0] up_q[$];

    branch_resolve #(
        .XLEN(32), .ROB_TAG_W(6), .UPD_DEPTH(4), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_valid(fu_valid), .fu_taken(fu_taken), .fu_link(fu_link),
        .fu_target(fu_target), .fu_pc(fu_pc), .fu_tag(fu_tag),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_mispredict(wb_mispredict),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_drop_cnt(upd_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: compares every presented output against the queued expectation
    always @(negedge clk) begin
        if (wb_valid) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 65'(wb_valid), 65'd0);
            else chk("wb", {26'd0, wb_tag, wb_data, wb_mispredict}, {26'd0, wb_q.pop_front()});
        end
        if (redirect_valid) begin
            if (rd_q.size() == 0) chk("redirect_unexpected", 65'(redirect_valid), 65'd0);
            else chk("redirect_pc", 65'(redirect_pc), 65'(rd_q.pop_front()));
        end
        if (upd_valid && upd_ready) begin
            if (up_q.size() == 0) chk("upd_unexpected", 65'(upd_valid), 65'd0);
            else chk("upd", {upd_pc, upd_taken, upd_target}, up_q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [5:0] tag, input logic taken,
                         input logic link, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptg, input logic acc, input logic mis,
                         input logic [31:0] exp_data, input logic [31:0] exp_rpc,
                         input logic enq);
        fu_valid = 1'b1; fu_pc = pc; fu_tag = tag; fu_taken = taken; fu_link = link;
        fu_target = tgt; pred_taken = ptk; pred_target = ptg;
        if (acc) wb_q.push_back({tag, exp_data, mis});
        if (acc && mis) rd_q.push_back(exp_rpc);
        if (enq) up_q.push_back({pc, taken, tgt});
        cyc();
        fu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fu_valid = 1'b0; fu_taken = 1'b0; fu_link = 1'b0; fu_target = '0;
        fu_pc = '0; fu_tag = '0; pred_taken = 1'b0; pred_target = '0; upd_ready = 1'b1;
        cyc(); cyc();
        chk("rst_wb_valid", 65'(wb_valid), 65'd0);
        chk("rst_redirect", 65'(redirect_valid), 65'd0);
        chk("rst_flush", 65'(flush), 65'd0);
        chk("rst_upd_valid", 65'(upd_valid), 65'd0);
        chk("rst_drop", 65'(upd_drop_cnt), 65'd0);
        rst = 1'b0;
        cyc();

        // correct not-taken
        drive(32'h100, 6'd1, 0, 0, 32'h180, 0, 32'h0, 1, 0, 32'h0, 32'h0, 1);
        chk("nt_flush", 65'(flush), 65'd0);
        cyc();

        // direction mispredict: flush two cycles, inputs dropped
        drive(32'h200, 6'd2, 1, 0, 32'h400, 0, 32'h0, 1, 1, 32'h0, 32'h400, 1);
        chk("dir_flush1", 65'(flush), 65'd1);
        drive(32'h204, 6'd40, 1, 1, 32'h999, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("dir_flush2", 65'(flush), 65'd1);
        drive(32'h208, 6'd41, 0, 1, 32'h0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("dir_flush_end", 65'(flush), 65'd0);

        // JALR target mispredict accepted right after flush ends
        drive(32'h300, 6'd3, 1, 1, 32'h800, 1, 32'h700, 1, 1, 32'h304, 32'h800, 1);
        chk("jalr_flush1", 65'(flush), 65'd1);
        cyc(); cyc();
        chk("jalr_flush_end", 65'(flush), 65'd0);

        // back-to-back correct results
        drive(32'h500, 6'd4, 1, 1, 32'h600, 1, 32'h600, 1, 0, 32'h504, 32'h0, 1);
        drive(32'h504, 6'd5, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 1);
        cyc(); cyc(); cyc();
        chk("drained_before_full", 65'(upd_valid), 65'd0);

        // fill FIFO with predictor stalled: 4 held, 2 dropped
        upd_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            drive(32'h1000 + 32'(i * 4), 6'(8 + i), 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0, (i < 4));
        chk("drop_cnt_2", 65'(upd_drop_cnt), 65'd2);
        chk("full_upd_valid", 65'(upd_valid), 65'd1);

        // full with simultaneous pop and push: no drop
        upd_ready = 1'b1;
        drive(32'h2000, 6'd20, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 1);
        chk("popush_drop", 65'(upd_drop_cnt), 65'd2);
        for (int i = 0; i < 6; i++) cyc();
        chk("drained_after_full", 65'(upd_valid), 65'd0);
        chk("upd_q_empty_mid", 65'(up_q.size()), 65'd0);

        // reset in second flush cycle; FIFO must be emptied
        upd_ready = 1'b0;
        drive(32'h700, 6'd21, 0, 0, 32'h0, 1, 32'h0, 1, 1, 32'h0, 32'h704, 1);
        chk("rstf_flush1", 65'(flush), 65'd1);
        cyc();
        chk("rstf_flush2", 65'(flush), 65'd1);
        rst = 1'b1;
        cyc();
        up_q.delete();
        chk("rstf_flush", 65'(flush), 65'd0);
        chk("rstf_redirect", 65'(redirect_valid), 65'd0);
        chk("rstf_wb", 65'(wb_valid), 65'd0);
        chk("rstf_upd_valid", 65'(upd_valid), 65'd0);
        chk("rstf_drop", 65'(upd_drop_cnt), 65'd0);
        rst = 1'b0;
        upd_ready = 1'b1;
        drive(32'h900, 6'd30, 0, 1, 32'h0, 0, 32'h0, 1, 0, 32'h904, 32'h0, 1);
        chk("post_rst_flush", 65'(flush), 65'd0);
        cyc(); cyc(); cyc();

        chk("wb_q_empty", 65'(wb_q.size()), 65'd0);
        chk("rd_q_empty", 65'(rd_q.size()), 65'd0);
        chk("up_q_empty", 65'(up_q.size()), 65'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
